round_robin_requester_with_2_channels: RTL and testbench
========================================================

ROUND_ROBIN_REQUESTER_WITH_2_CHANNELS -- requirements
Module: round_robin_requester_with_2_channels

Interface
REQ-001 Parameter DEPTH, default 4, maximum pending jobs per channel (1..15).
REQ-002 Parameter TIMEOUT, default 8, starvation threshold in cycles (1..255).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 job_valid  input  2  per-channel job offer; bit i offers one job to channel i.
REQ-006 job_ready  output  2  per-channel acceptance; bit i high when channel i count < DEPTH.
REQ-007 requests  output  2  arbiter requests; bit i high when channel i count > 0.
REQ-008 grants  input  2  arbiter grants, sampled in the same cycle as requests.
REQ-009 done  output  2  registered one-cycle pulse per completed (granted) job.
REQ-010 pending_0, pending_1  output  4 each  current job count per channel.
REQ-011 error  output  1  sticky protocol-violation flag.
REQ-012 starved  output  2  per-channel starvation flag.

Function
REQ-013 Per channel i: accept = job_valid[i] & job_ready[i]; consume = requests[i] & grants[i].
REQ-014 Count update at posedge: +1 on accept only, -1 on consume only, unchanged on both or neither.
REQ-015 job_valid[i] with job_ready[i] low (count == DEPTH) is dropped; count stays DEPTH.
REQ-016 Full with simultaneous consume: job_ready still low that cycle; offered job dropped, count becomes DEPTH-1.
REQ-017 requests and job_ready are combinational from count registers only; no path from grants or job_valid.
REQ-018 done[i] = consume registered: pulses exactly one cycle after each consume cycle; back-to-back consumes give back-to-back pulses.
REQ-019 Count with value 1 and consume: requests[i] drops the following cycle unless an accept occurred in the same cycle.
REQ-020 error sets at posedge when grants[i] & ~requests[i] for any i, or grants == 2'b11; remains set until reset.
REQ-021 A grant on a channel with no pending job never changes its count and never produces done.
REQ-022 Channels are fully independent except for the shared error flag.

Reset
REQ-023 rst low at posedge: counts 0, done 0, error 0, starved 0, wait counters 0; requests 0 and job_ready 2'b11 follow.
REQ-024 Reset mid-operation discards all pending jobs; no done pulse issues for them; job_valid and grants ignored during reset cycles.
REQ-025 First job acceptance possible in the first cycle with rst high.

Configuration
REQ-026 Macro ROUND_ROBIN_REQUESTER_STARVATION_EN defined: per-channel 8-bit wait counter increments each cycle with requests[i] high and consume low, saturating at TIMEOUT; clears on consume or requests[i] low.
REQ-027 With macro: starved[i] high while wait counter == TIMEOUT; clears the cycle after the clearing consume.
REQ-028 Without macro: no wait counters instantiated, starved tied to 2'b00; all other behaviour identical.

Verification
REQ-029 Reset, then job_valid=01 for 3 cycles, grants=00 -> pending_0=3, requests=01, job_ready=11, error=0.
REQ-030 Channel 0 holding 4 jobs (DEPTH 4), job_valid=01 -> job_ready[0]=0, pending_0 stays 4; then grants=01 with job_valid=01 -> pending_0=3, done[0] pulses next cycle.
REQ-031 pending_1=1, job_valid=10 and grants=10 same cycle -> pending_1 stays 1, requests[1] stays high, done[1] pulses once.
REQ-032 requests=00, grants=01 -> error=1 next cycle and remains 1 after grants=00 until rst low.
REQ-033 Macro defined, TIMEOUT=8, channel 1 pending, grants=00 for 8 cycles -> starved=10; grants=10 one cycle -> starved=00 following cycle; without macro starved=00 throughout.
REQ-034 Both channels with 2 jobs, rst low mid-stream -> next cycle pending_0=pending_1=0, requests=00, no done pulses.

Source files
------------

// File: rtl/round_robin_requester_with_2_channels_if.sv
// round_robin_requester_with_2_channels_if: job/arbiter handshake bundle for the two-channel requester
interface round_robin_requester_with_2_channels_if;
  logic [1:0] job_valid;
  logic [1:0] job_ready;
  logic [1:0] requests;
  logic [1:0] grants;
  logic [1:0] done;
  logic [3:0] pending_0;
  logic [3:0] pending_1;
  logic       error;
  logic [1:0] starved;
  modport master (
    output job_valid, grants,
    input  job_ready, requests, done, pending_0, pending_1, error, starved
  );
  modport slave (
    input  job_valid, grants,
    output job_ready, requests, done, pending_0, pending_1, error, starved
  );
endinterface

// File: rtl/round_robin_requester_with_2_channels.sv
// round_robin_requester_with_2_channels: per-channel job counters feeding an external arbiter.
// Starvation tracking is built only when ROUND_ROBIN_REQUESTER_STARVATION_EN is defined.
module round_robin_requester_with_2_channels #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input logic clk,
  input logic rst,
  round_robin_requester_with_2_channels_if.slave bus
);
  if (DEPTH < 1 || DEPTH > 15) $error("DEPTH out of range");
  if (TIMEOUT < 1 || TIMEOUT > 255) $error("TIMEOUT out of range");
  logic [1:0][3:0] r_cnt;
  logic [1:0]      r_done;
  logic            r_error;
  logic [1:0]      w_ready;
  logic [1:0]      w_req;
  logic [1:0]      w_accept;
  logic [1:0]      w_consume;
  assign w_ready   = {r_cnt[1] < 4'(DEPTH), r_cnt[0] < 4'(DEPTH)};
  assign w_req     = {|r_cnt[1], |r_cnt[0]};
  assign w_accept  = bus.job_valid & w_ready;
  assign w_consume = bus.grants & w_req;
  // accept and consume in the same cycle cancel in the modular sum
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_done  <= '0;
      r_error <= 1'b0;
    end else begin
      for (int k = 0; k < 2; k++)
        r_cnt[k] <= r_cnt[k] + 4'(w_accept[k]) - 4'(w_consume[k]);
      r_done  <= w_consume;
      r_error <= r_error | (|(bus.grants & ~w_req)) | (&bus.grants);
    end
  end
  assign bus.job_ready = w_ready;
  assign bus.requests  = w_req;
  assign bus.done      = r_done;
  assign bus.pending_0 = r_cnt[0];
  assign bus.pending_1 = r_cnt[1];
  assign bus.error     = r_error;
`ifdef ROUND_ROBIN_REQUESTER_STARVATION_EN
  logic [1:0][7:0] r_wait;
  always_ff @(posedge clk) begin
    if (!rst) r_wait <= '0;
    else
      for (int k = 0; k < 2; k++)
        r_wait[k] <= (w_consume[k] | ~w_req[k]) ? 8'd0 :
                     (r_wait[k] == 8'(TIMEOUT)) ? r_wait[k] : r_wait[k] + 8'd1;
  end
  assign bus.starved = {r_wait[1] == 8'(TIMEOUT), r_wait[0] == 8'(TIMEOUT)};
`else
  assign bus.starved = 2'b00;
`endif
endmodule

// File: tb/tb_round_robin_requester_with_2_channels.sv
// tb_round_robin_requester_with_2_channels: directed scenarios plus random traffic against a job-count model
module tb_round_robin_requester_with_2_channels;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  round_robin_requester_with_2_channels_if bus();
  round_robin_requester_with_2_channels #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int passed = 0;
  int m_cnt[2] = '{0, 0};
  int m_wait[2] = '{0, 0};
  logic [1:0] m_done = 2'b00;
  logic m_err = 1'b0;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic step(input logic [1:0] jv, input logic [1:0] gr, input logic rn);
    logic [1:0] exp_starved;
    bus.job_valid = jv;
    bus.grants    = gr;
    rst           = rn;
    @(posedge clk);
    if (!rn) begin
      m_cnt  = '{0, 0};
      m_wait = '{0, 0};
      m_done = 2'b00;
      m_err  = 1'b0;
    end else begin
      if (gr == 2'b11) m_err = 1'b1;
      for (int c = 0; c < 2; c++) begin
        bit has, acc, con;
        has = m_cnt[c] > 0;
        acc = jv[c] && m_cnt[c] < DEPTH;
        con = has && gr[c];
        if (gr[c] && !has) m_err = 1'b1;
        m_cnt[c] = m_cnt[c] + int'(acc) - int'(con);
        m_done[c] = con;
        m_wait[c] = (con || !has) ? 0 : (m_wait[c] < TIMEOUT ? m_wait[c] + 1 : TIMEOUT);
      end
    end
    @(negedge clk);
`ifdef ROUND_ROBIN_REQUESTER_STARVATION_EN
    exp_starved = {m_wait[1] == TIMEOUT, m_wait[0] == TIMEOUT};
`else
    exp_starved = 2'b00;
`endif
    chk("pending_0", 8'(bus.pending_0), 8'(m_cnt[0]));
    chk("pending_1", 8'(bus.pending_1), 8'(m_cnt[1]));
    chk("requests", 8'(bus.requests), 8'({m_cnt[1] > 0, m_cnt[0] > 0}));
    chk("job_ready", 8'(bus.job_ready), 8'({m_cnt[1] < DEPTH, m_cnt[0] < DEPTH}));
    chk("done", 8'(bus.done), 8'(m_done));
    chk("error", 8'(bus.error), 8'(m_err));
    chk("starved", 8'(bus.starved), 8'(exp_starved));
  endtask
  initial begin
    logic [1:0] gr, req;
    bus.job_valid = 2'b00;
    bus.grants    = 2'b00;
    step(2'b00, 2'b00, 1'b0);
    step(2'b11, 2'b11, 1'b0);
    chk("reset_ready", 8'(bus.job_ready), 8'h03);
    chk("reset_error", 8'(bus.error), 8'h00);
    repeat (3) step(2'b01, 2'b00, 1'b1);
    chk("r029_pend0", 8'(bus.pending_0), 8'h03);
    chk("r029_req", 8'(bus.requests), 8'h01);
    chk("r029_ready", 8'(bus.job_ready), 8'h03);
    step(2'b01, 2'b00, 1'b1);
    step(2'b01, 2'b00, 1'b1);
    chk("full_ready", 8'(bus.job_ready), 8'h02);
    chk("full_pend0", 8'(bus.pending_0), 8'h04);
    step(2'b01, 2'b01, 1'b1);
    chk("full_consume_pend0", 8'(bus.pending_0), 8'h03);
    chk("full_consume_done", 8'(bus.done), 8'h01);
    step(2'b00, 2'b00, 1'b1);
    chk("done_one_cycle", 8'(bus.done), 8'h00);
    step(2'b10, 2'b00, 1'b1);
    step(2'b10, 2'b10, 1'b1);
    chk("r031_pend1", 8'(bus.pending_1), 8'h01);
    chk("r031_req1", 8'(bus.requests[1]), 8'h01);
    chk("r031_done", 8'(bus.done), 8'h02);
    step(2'b00, 2'b00, 1'b1);
    repeat (3) step(2'b00, 2'b01, 1'b1);
    step(2'b00, 2'b10, 1'b1);
    chk("drained_req", 8'(bus.requests), 8'h00);
    step(2'b00, 2'b01, 1'b1);
    chk("r032_err_set", 8'(bus.error), 8'h01);
    chk("r032_no_done", 8'(bus.done), 8'h00);
    step(2'b00, 2'b00, 1'b1);
    chk("r032_err_sticky", 8'(bus.error), 8'h01);
    step(2'b00, 2'b00, 1'b0);
    chk("r032_err_clear", 8'(bus.error), 8'h00);
    step(2'b10, 2'b00, 1'b1);
    repeat (8) step(2'b00, 2'b00, 1'b1);
`ifdef ROUND_ROBIN_REQUESTER_STARVATION_EN
    chk("r033_starved", 8'(bus.starved), 8'h02);
`else
    chk("r033_starved", 8'(bus.starved), 8'h00);
`endif
    step(2'b00, 2'b10, 1'b1);
    chk("r033_unstarved", 8'(bus.starved), 8'h00);
    step(2'b00, 2'b11, 1'b1);
    chk("both_grant_err", 8'(bus.error), 8'h01);
    step(2'b00, 2'b00, 1'b0);
    repeat (2) step(2'b11, 2'b00, 1'b1);
    chk("r034_pre", 8'({bus.pending_1, bus.pending_0}), 8'h22);
    step(2'b11, 2'b01, 1'b0);
    chk("r034_pend", 8'({bus.pending_1, bus.pending_0}), 8'h00);
    chk("r034_req", 8'(bus.requests), 8'h00);
    chk("r034_done", 8'(bus.done), 8'h00);
    for (int n = 0; n < 800; n++) begin
      req = {m_cnt[1] > 0, m_cnt[0] > 0};
      gr  = 2'($urandom);
      if ($urandom_range(0, 19) != 0) begin
        gr = gr & req;
        if (gr == 2'b11) gr = $urandom_range(0, 1) ? 2'b01 : 2'b10;
      end
      step(2'($urandom), gr, $urandom_range(0, 39) != 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
